// File: rtl/sar_adc_ctrl_pkg.sv
// Shared types and constants for the successive-approximation ADC controller.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DECIDE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Two sync flops plus one cycle of ladder settling is the shortest safe hold time.
   localparam int SETTLE_MIN  = 3;
   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sar_adc_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module sync2
   import sar_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= '0;
      else     ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR controller: binary-searches dac_code against the synchronized comparator.
// Handshake: start is taken only in IDLE; done pulses for one cycle with result valid, result holds until the next done.
module sar_adc_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output state_t           state_dbg
);

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB_CODE = ONE << (WIDTH - 1);

   if (SETTLE_CYCLES < SETTLE_MIN) begin : g_bad_settle
      $error("sar_adc_ctrl: SETTLE_CYCLES must be at least %0d", SETTLE_MIN);
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("sar_adc_ctrl: WIDTH must be at least 2");
   end

   state_t            state;
   logic [CW-1:0]     settle_cnt;
   logic [IW-1:0]     bit_idx;
   logic              cmp_s;
   logic [WIDTH-1:0]  decided_code;
   logic [WIDTH-1:0]  next_trial;

   sync2 u_sync2 (
      .clk (clk),
      .rst (rst),
      .d   (cmp_in),
      .q   (cmp_s)
   );

   // The trial bit survives only when Vin >= Vdac; the next lower bit becomes the new trial.
   always_comb begin
      decided_code = cmp_s ? dac_code : (dac_code & ~(ONE << bit_idx));
      next_trial   = decided_code | (ONE << (bit_idx - IW'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dac_code   <= '0;
         result     <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         bit_idx    <= IW'(WIDTH - 1);
         settle_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SETTLE;
                  busy       <= 1'b1;
                  bit_idx    <= IW'(WIDTH - 1);
                  dac_code   <= MSB_CODE;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               if (settle_cnt == CW'(SETTLE_CYCLES - 1)) state <= DECIDE;
               else                                       settle_cnt <= settle_cnt + CW'(1);
            end
            DECIDE: begin
               if (bit_idx == '0) begin
                  dac_code <= decided_code;
                  result   <= decided_code;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  dac_code   <= next_trial;
                  bit_idx    <= bit_idx - IW'(1);
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end
            DONE: begin
               // In DONE only cont matters; a start here is dropped.
               if (cont) begin
                  state      <= SETTLE;
                  bit_idx    <= IW'(WIDTH - 1);
                  dac_code   <= MSB_CODE;
                  settle_cnt <= '0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with a behavioural comparator model.
module tb_sar_adc_ctrl;
   import sar_pkg::*;

   localparam int W    = 8;
   localparam int S    = 4;
   localparam int CONV = W * (S + 1);
   localparam int S7   = 7;
   localparam int CONV7 = W * (S7 + 1);

   logic         clk = 1'b0;
   logic         rst, start, cont;
   logic [W-1:0] vin_code, dac_code, result;
   logic         cmp_in, busy, done;
   state_t       state_dbg;

   logic         start7;
   logic [W-1:0] vin7, dac_code7, result7;
   logic         cmp7, busy7, done7;
   state_t       state_dbg7;

   always #5 clk = ~clk;

   assign cmp_in = (vin_code >= dac_code);
   assign cmp7   = (vin7 >= dac_code7);

   sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .cmp_in(cmp_in),
      .dac_code(dac_code), .busy(busy), .done(done), .result(result),
      .state_dbg(state_dbg)
   );

   sar_adc_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S7)) dut7 (
      .clk(clk), .rst(rst), .start(start7), .cont(1'b0), .cmp_in(cmp7),
      .dac_code(dac_code7), .busy(busy7), .done(done7), .result(result7),
      .state_dbg(state_dbg7)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] vin;
      logic [W-1:0] exp_result;
      logic [W-1:0] exp_trial1;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string name, input logic [W-1:0] act);
      if (exp_q.size() == 0) check({name, " queue_empty"}, 32'd0, 32'd1);
      else                   check(name, 32'(act), 32'(exp_q.pop_front()));
   endtask

   // Trial code while bit k is under test: vin's bits above k, bit k set, lower bits clear.
   function automatic logic [W-1:0] trial_code(input logic [W-1:0] vin, input int k);
      logic [W-1:0] c;
      c = '0;
      for (int b = W - 1; b > k; b--) c[b] = vin[b];
      c[k] = 1'b1;
      return c;
   endfunction

   task automatic run_conv(input logic [W-1:0] vin, input logic [W-1:0] t1, input string tag);
      int n;
      bit seen;
      seen = 0;
      vin_code = vin;
      start = 1'b1;
      exp_q.push_back(vin);
      tick;
      start = 1'b0;
      for (n = 1; n <= CONV + 10; n++) begin
         if (n <= CONV && (n - 1) % (S + 1) == 0)
            check({tag, " trial"}, 32'(dac_code), 32'(trial_code(vin, W - 1 - (n - 1) / (S + 1))));
         if (n == S + 2) check({tag, " trial1"}, 32'(dac_code), 32'(t1));
         if (done) begin
            seen = 1;
            break;
         end
         tick;
      end
      if (!seen) check({tag, " done_timeout"}, 32'd0, 32'd1);
      else begin
         check({tag, " latency"}, 32'(n), 32'(CONV + 1));
         pop_check({tag, " result"}, result);
         tick;
         check({tag, " busy_after"}, 32'(busy), 32'd0);
         check({tag, " done_pulse"}, 32'(done), 32'd0);
         check({tag, " result_hold"}, 32'(result), 32'(vin));
      end
   endtask

   initial begin
      int ndone;
      int first_at, second_at;
      bit dropped, seen;

      vecs[0] = '{8'hA5, 8'hA5, 8'hC0};
      vecs[1] = '{8'h00, 8'h00, 8'h40};
      vecs[2] = '{8'hFF, 8'hFF, 8'hC0};
      vecs[3] = '{8'h3C, 8'h3C, 8'h40};
      vecs[4] = '{8'h80, 8'h80, 8'hC0};
      vecs[5] = '{8'h7F, 8'h7F, 8'h40};
      vecs[6] = '{8'h01, 8'h01, 8'h40};
      vecs[7] = '{8'hFE, 8'hFE, 8'hC0};
      for (int i = 8; i < 12; i++) begin
         vecs[i].vin        = W'($urandom_range(0, 255));
         vecs[i].exp_result = vecs[i].vin;
         vecs[i].exp_trial1 = vecs[i].vin[7] ? 8'hC0 : 8'h40;
      end

      rst = 1'b1; start = 1'b0; cont = 1'b0; vin_code = '0;
      start7 = 1'b0; vin7 = '0;
      tick; tick;
      check("reset dac_code", 32'(dac_code), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset state", 32'(state_dbg), 32'(IDLE));
      rst = 1'b0;
      tick;
      check("idle dac_code", 32'(dac_code), 32'd0);

      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(vecs[i].exp_result);
         void'(exp_q.pop_back());
         run_conv(vecs[i].vin, vecs[i].exp_trial1, $sformatf("vec%0d", i));
         check($sformatf("vec%0d idle_dac", i), 32'(dac_code), 32'(vecs[i].exp_result));
      end

      // start held for 100 cycles: acceptances at T, T+42 and T+84
      vin_code = 8'h33;
      repeat (3) exp_q.push_back(8'h33);
      start = 1'b1;
      ndone = 0; first_at = 0; second_at = 0;
      tick;
      for (int n = 1; n < 100; n++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) first_at = n;
            if (ndone == 2) second_at = n;
            pop_check("held result", result);
         end
         tick;
      end
      start = 1'b0;
      check("held done_count", 32'(ndone), 32'd2);
      check("held first_done", 32'(first_at), 32'(CONV + 1));
      check("held second_done", 32'(second_at), 32'(2 * CONV + 3));
      seen = 0;
      for (int n = 100; n < 140; n++) begin
         if (done) begin
            check("held third_done", 32'(n), 32'(3 * CONV + 5));
            pop_check("held third result", result);
            seen = 1;
            break;
         end
         tick;
      end
      if (!seen) check("held third_timeout", 32'd0, 32'd1);
      tick;

      // Reset mid-conversion discards the partial code
      vin_code = 8'h99;
      start = 1'b1;
      exp_q.push_back(8'h99);
      tick;
      start = 1'b0;
      repeat (19) tick;
      rst = 1'b1;
      tick;
      exp_q.delete();
      check("midrst dac_code", 32'(dac_code), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst result", 32'(result), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      rst = 1'b0;
      tick;
      run_conv(8'h3C, 8'h40, "after_rst");

      // Continuous mode with vin changing between conversions
      vin_code = 8'h10;
      cont = 1'b1;
      start = 1'b1;
      exp_q.push_back(8'h10);
      tick;
      start = 1'b0;
      ndone = 0; dropped = 0;
      for (int n = 1; n < 2 * CONV + 20; n++) begin
         if (!busy) dropped = 1;
         if (n == CONV + 2) begin
            check("cont trial0_second", 32'(dac_code), 32'h80);
            cont = 1'b0;
         end
         if (done) begin
            ndone++;
            pop_check("cont result", result);
            if (ndone == 1) begin
               check("cont first_done", 32'(n), 32'(CONV + 1));
               vin_code = 8'hEE;
               exp_q.push_back(8'hEE);
            end else begin
               check("cont second_done", 32'(n), 32'(2 * CONV + 2));
               break;
            end
         end
         tick;
      end
      check("cont done_count", 32'(ndone), 32'd2);
      check("cont busy_held", 32'(dropped), 32'd0);
      tick;
      check("cont idle_after", 32'(busy), 32'd0);

      // SETTLE_CYCLES=7 instance
      vin7 = 8'h5A;
      start7 = 1'b1;
      exp_q.push_back(8'h5A);
      tick;
      start7 = 1'b0;
      seen = 0;
      for (int n = 1; n <= CONV7 + 10; n++) begin
         if (n <= CONV7 && (n - 1) % (S7 + 1) == 0)
            check("s7 trial", 32'(dac_code7), 32'(trial_code(8'h5A, W - 1 - (n - 1) / (S7 + 1))));
         if (done7) begin
            check("s7 latency", 32'(n), 32'(CONV7 + 1));
            pop_check("s7 result", result7);
            seen = 1;
            break;
         end
         tick;
      end
      if (!seen) check("s7 done_timeout", 32'd0, 32'd1);

      check("queue drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
